// File: rtl/match_scan_ctrl.sv
// match_scan_ctrl: walks a shared equality comparator over a small rule table,
// lowest index first, and reports hit/miss with saturating statistics.
module match_scan_ctrl #(
    parameter int KEY_W = 2,
    parameter int DEPTH = 4,
    parameter int IDX_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic             cfg_en,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    output logic [KEY_W-1:0] cmp_a,
    output logic [KEY_W-1:0] cmp_b,
    input  logic             cmp_eq,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [KEY_W-1:0] r_key [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [KEY_W-1:0] r_cmp_a;
    logic             r_hit;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic w_accept;
    logic w_match;
    logic w_last;
    logic w_done;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_match  = r_vld[r_ptr] && cmp_eq;
    assign w_last   = (r_ptr == IDX_W'(DEPTH - 1));
    assign w_done   = (r_state == RESP) && rsp_ready;

    assign cmp_a    = r_cmp_a;
    assign cmp_b    = r_key[r_ptr];
    assign rsp_hit  = r_hit;
    assign rsp_idx  = r_idx;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_match || w_last) w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Rule table; writes land in any state, so a compare sees the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_key[i] <= '0;
            r_vld <= '0;
        end else if (cfg_we) begin
            r_key[cfg_idx] <= cfg_key;
            r_vld[cfg_idx] <= cfg_en;
        end
    end

    // Key latch, scan pointer and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_a <= '0;
            r_ptr   <= '0;
            r_hit   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_cmp_a <= req_key;
            r_ptr   <= '0;
        end else if (r_state == SCAN) begin
            if (w_match) begin
                r_hit <= 1'b1;
                r_idx <= r_ptr;
            end else if (w_last) begin
                r_hit <= 1'b0;
                r_idx <= '0;
            end else begin
                r_ptr <= r_ptr + IDX_W'(1);
            end
        end
    end

    // Saturating statistics, bumped only on a completed response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_done) begin
            if (r_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_match_scan_ctrl.sv
// tb_match_scan_ctrl: scoreboard-driven bench for match_scan_ctrl
// with an ideal equality comparator on cmp_a/cmp_b.
module tb_match_scan_ctrl;

    localparam int KW = 2;
    localparam int D  = 4;
    localparam int IW = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [KW-1:0] cfg_key = '0;
    logic          cfg_en = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [KW-1:0] req_key = '0;
    logic [KW-1:0] cmp_a;
    logic [KW-1:0] cmp_b;
    logic          cmp_eq;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_hit;
    logic [IW-1:0] rsp_idx;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;
    logic          force_eq = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          hit;
        logic [IW-1:0] idx;
        int            lat;
    } exp_t;

    exp_t sb[$];

    assign cmp_eq = force_eq | (cmp_a == cmp_b);

    always #5 clk = ~clk;

    match_scan_ctrl #(
        .KEY_W(KW), .DEPTH(D), .IDX_W(IW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_key(cfg_key), .cfg_en(cfg_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        force_eq  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [IW-1:0] i,
                             input logic [KW-1:0] k,
                             input logic e);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = i;
        cfg_key = k;
        cfg_en  = e;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Drives one lookup and reports what came back and after how many edges.
    // cfg_at >= 0 raises a rule write in the cycle where the pointer equals cfg_at.
    task automatic run_lookup(input logic [KW-1:0] key,
                              input int cfg_at,
                              input logic [IW-1:0] ci,
                              input logic [KW-1:0] ck,
                              input logic ce,
                              output logic hit,
                              output logic [IW-1:0] idx,
                              output int lat);
        @(negedge clk);
        req_key   = key;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cfg_idx   = ci;
        cfg_key   = ck;
        cfg_en    = ce;
        cfg_we    = (cfg_at == 0);
        lat = -1;
        hit = 1'bx;
        idx = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cfg_we = 1'b0;
                lat = n;
                hit = rsp_hit;
                idx = rsp_idx;
                break;
            end
            cfg_we = (cfg_at == n);
        end
        cfg_we = 1'b0;
        if (lat > 0 && rsp_ready) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1 0",
                     req_ready, rsp_valid);
        end
        checks++;
        if (cmp_a !== '0 || cmp_b !== '0 || rsp_hit !== 1'b0 ||
            rsp_idx !== '0) begin
            errors++;
            $display("FAIL reset_dp: a=%0d b=%0d hit=%b idx=%0d want 0",
                     cmp_a, cmp_b, rsp_hit, rsp_idx);
        end
        checks++;
        if (hit_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: hit=%0d miss=%0d want 0 0",
                     hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_miss_empty();
        logic h;
        logic [IW-1:0] x;
        int l;
        exp_t e;
        sb.push_back('{1'b0, 2'd0, D});
        run_lookup(2'b01, -1, '0, '0, 1'b0, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL miss_empty: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
        checks++;
        if (miss_cnt !== 8'd1 || hit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL miss_cnt: miss=%0d hit=%0d want 1 0",
                     miss_cnt, hit_cnt);
        end
    endtask

    task automatic test_priority();
        logic h;
        logic [IW-1:0] x;
        int l;
        exp_t e;
        cfg_write(2'd0, 2'b00, 1'b1);
        cfg_write(2'd2, 2'b11, 1'b1);
        sb.push_back('{1'b1, 2'd2, 3});
        run_lookup(2'b11, -1, '0, '0, 1'b0, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL hit_idx2: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
        sb.push_back('{1'b1, 2'd0, 1});
        run_lookup(2'b00, -1, '0, '0, 1'b0, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL hit_idx0: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
        checks++;
        if (hit_cnt !== 8'd2 || miss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL prio_cnt: hit=%0d miss=%0d want 2 1",
                     hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_disable();
        logic h;
        logic [IW-1:0] x;
        int l;
        exp_t e;
        apply_reset();
        cfg_write(2'd1, 2'b10, 1'b1);
        cfg_write(2'd3, 2'b10, 1'b1);
        sb.push_back('{1'b1, 2'd1, 2});
        run_lookup(2'b10, -1, '0, '0, 1'b0, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL lowest_wins: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
        cfg_write(2'd1, 2'b10, 1'b0);
        sb.push_back('{1'b1, 2'd3, 4});
        run_lookup(2'b10, -1, '0, '0, 1'b0, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL disabled_skip: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
        apply_reset();
        force_eq = 1'b1;
        sb.push_back('{1'b0, 2'd0, D});
        run_lookup(2'b00, -1, '0, '0, 1'b0, h, x, l);
        force_eq = 1'b0;
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL disabled_eq1: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
    endtask

    task automatic test_backpressure();
        logic h;
        logic [IW-1:0] x;
        int l;
        int bad;
        exp_t e;
        apply_reset();
        cfg_write(2'd2, 2'b01, 1'b1);
        rsp_ready = 1'b0;
        sb.push_back('{1'b1, 2'd2, 3});
        run_lookup(2'b01, -1, '0, '0, 1'b0, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL bp_rsp: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
        bad = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 ||
                rsp_idx !== 2'd2 || req_ready !== 1'b0 ||
                hit_cnt !== 8'd0)
                bad++;
        end
        req_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || hit_cnt !== 8'd1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b hit_cnt=%0d ready=%b want 0 1 1",
                     rsp_valid, hit_cnt, req_ready);
        end
    endtask

    task automatic test_cfg_during_scan();
        logic h;
        logic [IW-1:0] x;
        int l;
        exp_t e;
        apply_reset();
        sb.push_back('{1'b1, 2'd3, 4});
        run_lookup(2'b01, 1, 2'd3, 2'b01, 1'b1, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL cfg_ahead: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
        cfg_write(2'd0, 2'b10, 1'b1);
        sb.push_back('{1'b1, 2'd3, 4});
        run_lookup(2'b01, 0, 2'd0, 2'b01, 1'b1, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL cfg_same_cyc: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
        sb.push_back('{1'b1, 2'd0, 1});
        run_lookup(2'b01, -1, '0, '0, 1'b0, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat) begin
            errors++;
            $display("FAIL cfg_landed: hit=%b idx=%0d lat=%0d want %b %0d %0d",
                     h, x, l, e.hit, e.idx, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        int t[3];
        int nr;
        int bad;
        apply_reset();
        cfg_write(2'd1, 2'b10, 1'b1);
        nr  = 0;
        bad = 0;
        @(negedge clk);
        req_key   = 2'b10;
        req_valid = 1'b1;
        for (int c = 1; c <= 40 && nr < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                t[nr] = c;
                if (rsp_hit !== 1'b1 || rsp_idx !== 2'd1) bad++;
                nr++;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (nr != 3 || bad != 0) begin
            errors++;
            $display("FAIL b2b_rsp: got %0d responses (%0d bad) want 3 (0 bad)",
                     nr, bad);
        end
        checks++;
        if (nr == 3 && (t[1] - t[0] != 4 || t[2] - t[1] != 4)) begin
            errors++;
            $display("FAIL b2b_period: gaps %0d %0d want 4 4",
                     t[1] - t[0], t[2] - t[1]);
        end
        checks++;
        if (hit_cnt !== 8'd3) begin
            errors++;
            $display("FAIL b2b_cnt: hit=%0d want 3", hit_cnt);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic h;
        logic [IW-1:0] x;
        int l;
        int seen;
        exp_t e;
        apply_reset();
        cfg_write(2'd3, 2'b11, 1'b1);
        @(negedge clk);
        req_key   = 2'b11;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_drop: rsp_valid high %0d cycles want 0", seen);
        end
        checks++;
        if (hit_cnt !== '0 || miss_cnt !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_state: hit=%0d miss=%0d ready=%b want 0 0 1",
                     hit_cnt, miss_cnt, req_ready);
        end
        sb.push_back('{1'b0, 2'd0, D});
        run_lookup(2'b11, -1, '0, '0, 1'b0, h, x, l);
        e = sb.pop_front();
        checks++;
        if (h !== e.hit || x !== e.idx || l !== e.lat || miss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rst_rules: hit=%b idx=%0d lat=%0d miss=%0d want %b %0d %0d 1",
                     h, x, l, miss_cnt, e.hit, e.idx, e.lat);
        end
    endtask

    task automatic test_saturation();
        logic h;
        logic [IW-1:0] x;
        int l;
        int bad;
        apply_reset();
        cfg_write(2'd0, 2'b01, 1'b1);
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            run_lookup(2'b01, -1, '0, '0, 1'b0, h, x, l);
            if (h !== 1'b1 || x !== 2'd0 || l != 1) bad++;
        end
        checks++;
        if (bad != 0 || hit_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_reach: hit_cnt=%0d bad=%0d want 255 0",
                     hit_cnt, bad);
        end
        run_lookup(2'b01, -1, '0, '0, 1'b0, h, x, l);
        checks++;
        if (hit_cnt !== 8'd255 || miss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sat_hold: hit=%0d miss=%0d want 255 0",
                     hit_cnt, miss_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_miss_empty();
        test_priority();
        test_disable();
        test_backpressure();
        test_cfg_during_scan();
        test_back_to_back();
        test_reset_mid_scan();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
